// File: rtl/alu.sv
// Registered 16-bit execute-stage ALU: result and {Z,C,F,N,L} status are updated every rising edge.
// Flags that an operation does not define keep their previous registered values.
module alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       Opcode,
  output logic [WIDTH-1:0] C,
  output logic [4:0]       Flags
);

  typedef enum logic [4:0] {
    OP_AND  = 5'b00001,
    OP_OR   = 5'b00010,
    OP_XOR  = 5'b00011,
    OP_NOT  = 5'b00100,
    OP_ADD  = 5'b00101,
    OP_ADDU = 5'b00110,
    OP_ADDC = 5'b00111,
    OP_SUB  = 5'b01001,
    OP_SUBC = 5'b01010,
    OP_CMP  = 5'b01011,
    OP_CMPU = 5'b01100,
    OP_MOV  = 5'b01101,
    OP_MUL  = 5'b01110,
    OP_LSH  = 5'b10000,
    OP_RSH  = 5'b10001,
    OP_ARSH = 5'b10010
  } opcode_t;

  localparam int ZB = 4;
  localparam int CB = 3;
  localparam int FB = 2;
  localparam int NB = 1;
  localparam int LB = 0;
  localparam int SH = $clog2(WIDTH);

  logic [WIDTH-1:0]   res;
  logic [4:0]         nflags;
  logic               add_cin;
  logic               sub_cin;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod;
  logic [SH-1:0]      shamt;

  always_comb begin
    add_cin = (Opcode == OP_ADDC) && Flags[CB];
    sub_cin = (Opcode == OP_SUBC) && Flags[CB];
    // Bit WIDTH of the zero-extended sum is the carry; of the difference it is the borrow.
    sum   = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, add_cin};
    diff  = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, sub_cin};
    prod  = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
    shamt = B[SH-1:0];
    res    = '0;
    nflags = Flags;
    case (Opcode)
      OP_AND, OP_OR, OP_XOR, OP_NOT, OP_MOV, OP_MUL, OP_LSH, OP_RSH, OP_ARSH: begin
        case (Opcode)
          OP_AND:  res = A & B;
          OP_OR:   res = A | B;
          OP_XOR:  res = A ^ B;
          OP_NOT:  res = ~A;
          OP_MOV:  res = B;
          OP_MUL:  res = prod[WIDTH-1:0];
          OP_LSH:  res = A << shamt;
          OP_RSH:  res = A >> shamt;
          default: res = WIDTH'($signed(A) >>> shamt);
        endcase
        nflags[ZB] = (res == '0);
        nflags[NB] = res[WIDTH-1];
      end
      OP_ADD, OP_ADDU, OP_ADDC: begin
        res = sum[WIDTH-1:0];
        nflags[ZB] = (res == '0);
        nflags[NB] = res[WIDTH-1];
        nflags[CB] = sum[WIDTH];
        nflags[FB] = (A[WIDTH-1] == B[WIDTH-1]) && (res[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB, OP_SUBC: begin
        res = diff[WIDTH-1:0];
        nflags[ZB] = (res == '0);
        nflags[NB] = res[WIDTH-1];
        nflags[CB] = diff[WIDTH];
        nflags[FB] = (A[WIDTH-1] != B[WIDTH-1]) && (res[WIDTH-1] != A[WIDTH-1]);
      end
      OP_CMP, OP_CMPU: begin
        res = diff[WIDTH-1:0];
        nflags[ZB] = (A == B);
        nflags[NB] = ($signed(A) < $signed(B));
        nflags[LB] = (A < B);
        nflags[CB] = diff[WIDTH];
        nflags[FB] = (A[WIDTH-1] != B[WIDTH-1]) && (res[WIDTH-1] != A[WIDTH-1]);
      end
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      C     <= '0;
      Flags <= '0;
    end else begin
      C     <= res;
      Flags <= nflags;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed and random checks of the registered ALU result and flags.
module tb_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] A;
  logic [15:0] B;
  logic [4:0]  Opcode;
  logic [15:0] C;
  logic [4:0]  Flags;

  int unsigned total = 0;
  int unsigned bad   = 0;

  alu #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .Opcode(Opcode), .C(C), .Flags(Flags)
  );

  always #5 clk = ~clk;

  task automatic step(input logic rst, input logic [4:0] op, input logic [15:0] a,
                      input logic [15:0] b, input logic [15:0] exp_c,
                      input logic [4:0] exp_f, input string tag);
    reset = rst; Opcode = op; A = a; B = b;
    @(posedge clk); #1;
    total++;
    assert (C === exp_c) else begin
      bad++;
      $error("FAIL %s result: got %h expected %h", tag, C, exp_c);
    end
    total++;
    assert (Flags === exp_f) else begin
      bad++;
      $error("FAIL %s flags: got %b expected %b", tag, Flags, exp_f);
    end
  endtask

  function automatic logic [15:0] ref_c(input logic [4:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    logic [31:0] p;
    case (op)
      5'b00101: return a + b;
      5'b01001: return a - b;
      5'b01110: begin p = {16'h0, a} * {16'h0, b}; return p[15:0]; end
      5'b00001: return a & b;
      5'b00010: return a | b;
      default:  return a ^ b;
    endcase
  endfunction

  initial begin
    logic [4:0] ops [6];
    logic [4:0] op;
    logic [15:0] a, b, exp_c;
    ops[0] = 5'b00101; ops[1] = 5'b01001; ops[2] = 5'b01110;
    ops[3] = 5'b00001; ops[4] = 5'b00010; ops[5] = 5'b00011;
    reset = 1'b1; Opcode = '0; A = '0; B = '0;
    @(posedge clk); #1;
    //             rst  op        A        B        C        {Z,C,F,N,L}
    step(1'b1, 5'b00101, 16'h1234, 16'h1111, 16'h0000, 5'b00000, "reset");
    step(1'b0, 5'b00101, 16'h7FFF, 16'h0001, 16'h8000, 5'b00110, "add_ovf");
    step(1'b0, 5'b00110, 16'hFFFF, 16'h0001, 16'h0000, 5'b11000, "addu_wrap");
    step(1'b0, 5'b00111, 16'h0002, 16'h0003, 16'h0006, 5'b00000, "addc_cin1");
    step(1'b0, 5'b01001, 16'h8000, 16'h0001, 16'h7FFF, 5'b00100, "sub_ovf");
    step(1'b0, 5'b01001, 16'h0000, 16'h0001, 16'hFFFF, 5'b01010, "sub_borrow");
    step(1'b0, 5'b01010, 16'h0005, 16'h0002, 16'h0002, 5'b00000, "subc_bin1");
    step(1'b0, 5'b01011, 16'hFFFE, 16'h0001, 16'hFFFD, 5'b00010, "cmp_neg");
    step(1'b0, 5'b01100, 16'h0001, 16'hFFFF, 16'h0002, 5'b01001, "cmpu_lt");
    step(1'b0, 5'b01011, 16'h1234, 16'h1234, 16'h0000, 5'b10000, "cmp_eq");
    step(1'b0, 5'b00001, 16'hF0F0, 16'hFF00, 16'hF000, 5'b00010, "and");
    step(1'b0, 5'b00010, 16'h0000, 16'h0000, 16'h0000, 5'b10000, "or_zero");
    step(1'b0, 5'b00100, 16'h00FF, 16'h0000, 16'hFF00, 5'b00010, "not");
    step(1'b0, 5'b00011, 16'hAAAA, 16'h5555, 16'hFFFF, 5'b00010, "xor");
    step(1'b0, 5'b01101, 16'h1234, 16'h0000, 16'h0000, 5'b10000, "mov");
    step(1'b0, 5'b10000, 16'h0001, 16'h0013, 16'h0008, 5'b00000, "lsh");
    step(1'b0, 5'b10001, 16'h8000, 16'h0004, 16'h0800, 5'b00000, "rsh");
    step(1'b0, 5'b10010, 16'h8000, 16'h0004, 16'hF800, 5'b00010, "arsh");
    step(1'b0, 5'b01110, 16'hFFFF, 16'h0003, 16'hFFFD, 5'b00010, "mul_neg");
    step(1'b0, 5'b00110, 16'hFFFF, 16'h0001, 16'h0000, 5'b11000, "addu_setc");
    step(1'b0, 5'b00001, 16'hFFFF, 16'h0001, 16'h0001, 5'b01000, "and_holdc");
    step(1'b0, 5'b01000, 16'h1234, 16'h5678, 16'h0000, 5'b01000, "illegal_op");
    step(1'b1, 5'b00110, 16'hFFFF, 16'h0001, 16'h0000, 5'b00000, "reset_mid");
    step(1'b0, 5'b00111, 16'h0002, 16'h0003, 16'h0005, 5'b00000, "addc_after_rst");

    reset = 1'b0;
    for (int i = 0; i < 60; i++) begin
      op = ops[$urandom_range(0, 5)];
      a = 16'($urandom);
      b = 16'($urandom);
      exp_c = ref_c(op, a, b);
      Opcode = op; A = a; B = b;
      @(posedge clk); #1;
      total++;
      assert (C === exp_c) else begin
        bad++;
        $error("FAIL rand op=%b a=%h b=%h: got %h expected %h", op, a, b, C, exp_c);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
